// File: rtl/inst_rom_loader_pkg.sv
// Shared widths and loader state encoding for the instruction ROM boot loader.
package inst_rom_loader_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int HDR_W       = 16;
    localparam int BYTE_W      = 8;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/inst_rom_loader_irom_mem.sv
// Instruction memory array: one synchronous write port, one asynchronous read port.
module irom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [2**ADDR_W];

    // No reset on the array: contents survive a loader reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader FSM feeding the instruction memory, plus gated combinational fetch port.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_valid_i,
    input  logic [BYTE_W-1:0]      ld_data_i,
    output logic                   ld_ready_o,
    input  logic                   rom_ce_i,
    input  logic [INST_ADDR_W-1:0] rom_addr_i,
    output logic [INST_W-1:0]      rom_data_o,
    output logic                   cpu_rst_o,
    output logic                   boot_done_o,
    output logic                   boot_err_o
);

    localparam logic [HDR_W:0] DEPTH = (HDR_W+1)'(1) << ADDR_W;

    ld_state_e           state_q, state_d;
    logic [HDR_W-1:0]    nwords_q;
    logic [HDR_W-1:0]    wcnt_q;
    logic [1:0]          bcnt_q;
    logic [23:0]         asm_q;
    logic                accept;
    logic                mem_we;
    logic [HDR_W-1:0]    hdr_n;
    logic                last_word;
    logic                addr_in_range;
    logic [INST_W-1:0]   mem_rdata;
    logic                unused_addr_bits;

    assign accept    = ld_valid_i & ld_ready_o;
    assign hdr_n     = {nwords_q[15:8], ld_data_i};
    assign last_word = (wcnt_q + 16'd1) == nwords_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HDR0: if (accept) state_d = ST_HDR1;
            ST_HDR1: begin
                if (accept) begin
                    if (hdr_n == '0) begin
                        state_d = ST_RUN;
                    end else if ({1'b0, hdr_n} > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: if (accept && bcnt_q == 2'd3 && last_word) state_d = ST_RUN;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        ld_ready_o  = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_LOAD);
        cpu_rst_o   = (state_q != ST_RUN);
        boot_done_o = (state_q == ST_RUN);
        boot_err_o  = (state_q == ST_ERR);
        mem_we      = accept && (state_q == ST_LOAD) && (bcnt_q == 2'd3);
    end

    // Only the first three bytes of a word need holding; the fourth goes straight to memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nwords_q <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            unique case (state_q)
                ST_HDR0: nwords_q[15:8] <= ld_data_i;
                ST_HDR1: nwords_q[7:0]  <= ld_data_i;
                ST_LOAD: begin
                    asm_q <= {asm_q[15:0], ld_data_i};
                    if (bcnt_q == 2'd3) begin
                        bcnt_q <= '0;
                        wcnt_q <= wcnt_q + 16'd1;
                    end else begin
                        bcnt_q <= bcnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    irom_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wcnt_q[ADDR_W-1:0]),
        .wdata ({asm_q, ld_data_i}),
        .raddr (rom_addr_i[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    // Fetches are word-aligned; the byte offset is deliberately dropped.
    assign unused_addr_bits = ^rom_addr_i[1:0];
    assign addr_in_range    = (rom_addr_i[INST_ADDR_W-1:ADDR_W+2] == '0);
    assign rom_data_o       = (rom_ce_i && addr_in_range && state_q == ST_RUN) ? mem_rdata : '0;

endmodule
